fifo_prog: RTL and testbench
============================

Name: fifo_prog

Overview:
- Parametrised successor to the team's single-clock FIFO.
- Depth may be any value ≥ 2, including non-powers-of-two.
- Adds an exact occupancy count, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a read-valid strobe and optional first-word-fall-through (FWFT) mode.
- Sits between producer/consumer datapath stages in the same clock domain.

Parameters:
- WORD_WIDTH, 8: data word width in bits.
- DEPTH, 128: number of storage words, ≥ 2, any integer.
- CW, $clog2(DEPTH+1): count/threshold width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_w_en  in  1  write request.
- i_w_data  in  WORD_WIDTH  write data.
- i_r_en  in  1  read request.
- i_afull_thresh  in  CW  o_afull asserts when count ≥ this value.
- i_aempty_thresh  in  CW  o_aempty asserts when count ≤ this value.
- i_clr_err  in  1  synchronous clear of the sticky error flags.
- o_r_data  out  WORD_WIDTH  read data.
- o_r_valid  out  1  o_r_data holds a newly popped word.
- o_count  out  CW  current occupancy, 0..DEPTH.
- o_full, o_afull, o_empty, o_aempty  out  1 each  status flags.
- o_overflow, o_underflow  out  1 each  sticky error flags.

Behaviour:
- **Reset and clock:** reset is asynchronous, active-high; single clock clk. While reset is asserted:
  - wr_ptr, rd_ptr, count, o_r_data, o_r_valid, o_overflow and o_underflow are 0.
  - o_empty=1, o_full=0, o_aempty=1.
  - o_afull = (i_afull_thresh==0).
  - Memory contents are not reset.
- **Reset mid-operation:** discards all contents. The first write after deassertion lands in slot 0.
- **Occupancy:** count is an explicit CW-bit register, not derived from pointer difference. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- **Status flags:** all combinational from registered count, so they reflect state as of the last edge.
  - o_full = (count==DEPTH); o_empty = (count==0).
  - o_afull = (count ≥ i_afull_thresh); o_aempty = (count ≤ i_aempty_thresh).
  - Thresholds are sampled live and may change at any time.
- **Read acceptance:** rd_ok = i_r_en && !o_empty.
- **Write acceptance:** wr_ok = i_w_en && (!o_full || rd_ok).
  - When full, a simultaneous read and write are both accepted; count is unchanged.
  - When empty, a simultaneous read and write: the write is accepted, the read is rejected (underflow), and count becomes 1.
- **Accepted write:** mem[wr_ptr] ← i_w_data, wr_ptr advances.
- **Accepted read:** rd_ptr advances.
- **Count update:** count += wr_ok − rd_ok, computed without overflow at CW bits.
- **Error flags:**
  - o_overflow sets on the cycle after i_w_en && !wr_ok.
  - o_underflow sets on the cycle after i_r_en && !rd_ok.
  - Both hold until i_clr_err or reset.
  - If i_clr_err coincides with a new error event, set wins.
- **Read timing (standard mode):** one-cycle latency.
  - On rd_ok at edge N, o_r_data = mem[old rd_ptr] after edge N, and o_r_valid=1 for exactly that one cycle.
  - o_r_data holds its last value otherwise.
  - Rejected reads leave o_r_data unchanged and o_r_valid=0.
- **Write-to-read visibility:** a word written at edge N is readable (rd_ok possible) from the cycle after edge N.

Optional Feature:
- Macro FIFO_PROG_FWFT_EN.
- **Defined (FWFT mode):**
  - o_r_data = mem[rd_ptr] combinationally whenever !o_empty, and 0 when empty.
  - o_r_valid = !o_empty (combinational).
  - i_r_en acts as a pop/acknowledge of the presented word, which then advances.
  - Acceptance rules, count, flags and error behaviour are unchanged.
  - A word written into an empty FIFO at edge N appears on o_r_data after edge N.
- **Not defined:** standard registered one-cycle-latency read exactly as in Behaviour.

Test Plan:
1. Reset/flags. DEPTH=6, WORD_WIDTH=8, thresholds afull=5, aempty=1, reset pulsed mid-stream → o_empty=1, o_aempty=1, o_afull=0, o_count=0, o_r_valid=0; stale data is not readable after reset.
2. Fill/wrap.
   - Write 0x10..0x15 → o_count=6, o_full=1, o_afull=1 from count 5.
   - 7th write (0x16) is rejected → o_overflow=1 next cycle, count stays 6.
   - Read 6 words → 0x10..0x15 in order, each with a one-cycle o_r_valid pulse.
   - Continue 20 more write/read pairs → pointers wrap at 5→0 with no data loss.
3. Full simultaneous. FIFO holding 0x10..0x15, i_w_en=i_r_en=1 with 0xAA → 0x10 is read, 0xAA is accepted, count stays 6, o_overflow stays 0.
4. Empty simultaneous. Empty FIFO, i_w_en=i_r_en=1 with 0x55 → count=1, o_underflow=1, o_r_valid=0. Next-cycle read returns 0x55.
5. Thresholds/errors.
   - Count=3 with afull thresh changed 4→3 → o_afull rises the same cycle.
   - i_clr_err pulse → both sticky flags clear.
   - i_clr_err coincident with an underflow event → o_underflow remains 1.
6. FWFT build (FIFO_PROG_FWFT_EN).
   - Write 0x3C into an empty FIFO → next cycle o_r_data=0x3C, o_r_valid=1 with no read issued.
   - Pop → o_r_valid=0, o_empty=1.

Source files
------------

// File: rtl/fifo_prog.sv
// Single-clock FIFO with exact occupancy, programmable almost-full/almost-empty
// thresholds, sticky error flags and read-valid strobe. Define FIFO_PROG_FWFT_EN for first-word-fall-through reads.
module fifo_prog #(
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int CW         = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_w_en,
  input  logic [WORD_WIDTH-1:0] i_w_data,
  input  logic                  i_r_en,
  input  logic [CW-1:0]         i_afull_thresh,
  input  logic [CW-1:0]         i_aempty_thresh,
  input  logic                  i_clr_err,
  output logic [WORD_WIDTH-1:0] o_r_data,
  output logic                  o_r_valid,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_afull,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic                  rd_ok, wr_ok;

  assign o_count  = count;
  assign o_full   = (count == CW'(DEPTH));
  assign o_empty  = (count == '0);
  assign o_afull  = (count >= i_afull_thresh);
  assign o_aempty = (count <= i_aempty_thresh);

  // A read frees a slot in the same edge, so a full FIFO may still accept a write.
  assign rd_ok = i_r_en && !o_empty;
  assign wr_ok = i_w_en && (!o_full || rd_ok);

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= i_w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      // A new error event in the same cycle as a clear keeps the flag set.
      o_overflow  <= (o_overflow  && !i_clr_err) || (i_w_en && !wr_ok);
      o_underflow <= (o_underflow && !i_clr_err) || (i_r_en && !rd_ok);
    end
  end

`ifdef FIFO_PROG_FWFT_EN
  assign o_r_data  = o_empty ? '0 : mem[rd_ptr];
  assign o_r_valid = !o_empty;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_r_data  <= '0;
      o_r_valid <= 1'b0;
    end else begin
      o_r_valid <= rd_ok;
      if (rd_ok) o_r_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Randomised and directed bench for fifo_prog (DEPTH=6) against a queue-based
// model; honours FIFO_PROG_FWFT_EN when defined.
module tb_fifo_prog;

  localparam int WW    = 8;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0, r_en = 1'b0, clr = 1'b0;
  logic [WW-1:0] w_data = '0;
  logic [CW-1:0] afull_th = CW'(5), aempty_th = CW'(1);
  logic [WW-1:0] r_data;
  logic          r_valid, full, afull, empty, aempty, ovf, unf;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  fifo_prog #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst), .i_w_en(w_en), .i_w_data(w_data), .i_r_en(r_en),
    .i_afull_thresh(afull_th), .i_aempty_thresh(aempty_th), .i_clr_err(clr),
    .o_r_data(r_data), .o_r_valid(r_valid), .o_count(count), .o_full(full),
    .o_afull(afull), .o_empty(empty), .o_aempty(aempty),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  // Behavioural model: contents as a queue, registered outputs as plain variables.
  logic [WW-1:0] q[$];
  logic [WW-1:0] m_rdata = '0;
  bit            m_rvalid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rdata = '0; m_rvalid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit rd, wr;
      rd = r_en && (q.size() > 0);
      wr = w_en && ((q.size() < DEPTH) || rd);
      m_ovf = (m_ovf && !clr) || (w_en && !wr);
      m_unf = (m_unf && !clr) || (r_en && !rd);
      m_rvalid = rd;
      if (rd) m_rdata = q.pop_front();
      if (wr) q.push_back(w_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      int n;
      n = q.size();
      chk("count",  32'(count),  32'(n));
      chk("full",   32'(full),   32'(n == DEPTH));
      chk("empty",  32'(empty),  32'(n == 0));
      chk("afull",  32'(afull),  32'(n >= int'(afull_th)));
      chk("aempty", 32'(aempty), 32'(n <= int'(aempty_th)));
      chk("ovf",    32'(ovf),    32'(m_ovf));
      chk("unf",    32'(unf),    32'(m_unf));
`ifdef FIFO_PROG_FWFT_EN
      chk("rvalid", 32'(r_valid), 32'(n > 0));
      chk("rdata",  32'(r_data),  (n > 0) ? 32'(q[0]) : 32'd0);
`else
      chk("rvalid", 32'(r_valid), 32'(m_rvalid));
      chk("rdata",  32'(r_data),  32'(m_rdata));
`endif
    end
  end

  // Inputs change 2 time units after the rising edge, well away from both edges.
  task automatic step(input bit w, input logic [WW-1:0] d, input bit r, input bit c);
    w_en = w; w_data = d; r_en = r; clr = c;
    @(posedge clk); #2;
    w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    checking = 1'b1;

    // Reset mid-stream discards contents.
    step(1, 8'h01, 0, 0);
    step(1, 8'h02, 0, 0);
    rst = 1'b1; @(posedge clk); #2 rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(aempty), 32'd1);
    chk("rst_afull", 32'(afull), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    step(0, 8'h00, 1, 0);
    chk("stale_unf", 32'(unf), 32'd1);
`ifndef FIFO_PROG_FWFT_EN
    chk("stale_rvalid", 32'(r_valid), 32'd0);
`endif
    step(1, 8'h77, 0, 1);
    step(0, 8'h00, 1, 0);
`ifndef FIFO_PROG_FWFT_EN
    chk("slot0_data", 32'(r_data), 32'h77);
`endif

    // Fill, overflow, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, WW'(8'h10 + i), 0, 0);
      if (i == 4) chk("afull_at5", 32'(afull), 32'd1);
    end
    chk("fill_count", 32'(count), 32'd6);
    chk("fill_full", 32'(full), 32'd1);
    step(1, 8'h16, 0, 0);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd6);
    for (int i = 0; i < DEPTH; i++) begin
`ifdef FIFO_PROG_FWFT_EN
      chk("fwft_drain", 32'(r_data), 32'(8'h10 + i));
      step(0, 8'h00, 1, 0);
`else
      step(0, 8'h00, 1, 0);
      chk("drain_data", 32'(r_data), 32'(8'h10 + i));
      chk("drain_valid", 32'(r_valid), 32'd1);
`endif
    end
    step(0, 8'h00, 0, 1);
    // Wrap pointers with steady write/read pairs.
    step(1, 8'h80, 0, 0);
    for (int i = 1; i <= 20; i++) step(1, WW'(8'h80 + i), 1, 0);
    step(0, 8'h00, 1, 0);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) step(1, WW'(8'h10 + i), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("fs_count", 32'(count), 32'd6);
    chk("fs_ovf", 32'(ovf), 32'd0);
`ifndef FIFO_PROG_FWFT_EN
    chk("fs_data", 32'(r_data), 32'h10);
`endif
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0);

    // Empty with simultaneous read and write.
    step(1, 8'h55, 1, 0);
    chk("es_count", 32'(count), 32'd1);
    chk("es_unf", 32'(unf), 32'd1);
`ifndef FIFO_PROG_FWFT_EN
    chk("es_rvalid", 32'(r_valid), 32'd0);
`endif
    step(0, 8'h00, 1, 1);
`ifndef FIFO_PROG_FWFT_EN
    chk("es_data", 32'(r_data), 32'h55);
`endif

    // Live thresholds and sticky flag clearing.
    for (int i = 0; i < 3; i++) step(1, WW'(8'h20 + i), 0, 0);
    afull_th = CW'(4); #1;
    chk("th4_afull", 32'(afull), 32'd0);
    afull_th = CW'(3); #1;
    chk("th3_afull", 32'(afull), 32'd1);
    afull_th = CW'(5);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("unf_event", 32'(unf), 32'd1);
    step(0, 8'h00, 1, 1);
    chk("clr_vs_set", 32'(unf), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("clr_unf", 32'(unf), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);

`ifdef FIFO_PROG_FWFT_EN
    step(1, 8'h3C, 0, 0);
    chk("fwft_data", 32'(r_data), 32'h3C);
    chk("fwft_valid", 32'(r_valid), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("fwft_pop_valid", 32'(r_valid), 32'd0);
    chk("fwft_pop_empty", 32'(empty), 32'd1);
`endif

    // Random traffic with moving thresholds, occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        afull_th  = CW'($urandom_range(0, 7));
        aempty_th = CW'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1; @(posedge clk); #2 rst = 1'b0;
      end else begin
        int phase;
        phase = (i / 200) % 3;
        step(($urandom_range(0, 9) < (phase == 0 ? 7 : (phase == 1 ? 3 : 5))),
             WW'($urandom), ($urandom_range(0, 9) < (phase == 0 ? 3 : (phase == 1 ? 7 : 5))),
             ($urandom_range(0, 19) == 0));
      end
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
